// File: rtl/cellram_pkg.sv
// Shared widths, port indices, default region bases and FSM encoding for the
// cellular-RAM read arbiter.
package cellram_pkg;

    localparam int RAM_AW = 23;
    localparam int REQ_AW = 20;
    localparam int DW     = 16;

    localparam logic PORT_CHR = 1'b0;
    localparam logic PORT_PRG = 1'b1;

    localparam logic [RAM_AW-1:0] CHR_BASE_DEF = 23'h000000;
    localparam logic [RAM_AW-1:0] PRG_BASE_DEF = 23'h100000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    // Region offset is applied modulo 2^23, so a base near the top wraps.
    function automatic logic [RAM_AW-1:0] map_addr(input logic [RAM_AW-1:0] base,
                                                   input logic [REQ_AW-1:0] addr);
        return base + {{(RAM_AW-REQ_AW){1'b0}}, addr};
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin grant; the caller owns the last-grant register.
module rr_arb2
    import cellram_pkg::*;
(
    input  logic req0_i,
    input  logic req1_i,
    input  logic last_grant_i,
    output logic gnt_vld_o,
    output logic gnt_port_o
);

    always_comb begin
        gnt_vld_o  = req0_i | req1_i;
        gnt_port_o = PORT_CHR;
        if (req0_i && req1_i) begin
            gnt_port_o = ~last_grant_i;
        end else if (req1_i) begin
            gnt_port_o = PORT_PRG;
        end
    end

endmodule

// File: rtl/cellram_arbiter.sv
// Round-robin CHR/PRG read arbiter driving async cellular RAM with a fixed
// number of wait states per word; every output comes straight from a flop.
module cellram_arbiter
    import cellram_pkg::*;
#(
    parameter int unsigned       WAIT_CYCLES = 7,
    parameter logic [RAM_AW-1:0] CHR_BASE    = CHR_BASE_DEF,
    parameter logic [RAM_AW-1:0] PRG_BASE    = PRG_BASE_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              chr_req,
    input  logic [REQ_AW-1:0] chr_addr,
    output logic              chr_req_ack,
    output logic              chr_ready,
    input  logic              prg_req,
    input  logic [REQ_AW-1:0] prg_addr,
    output logic              prg_req_ack,
    output logic              prg_ready,
    output logic [DW-1:0]     rd_data,
    output logic [RAM_AW-1:0] ram_a,
    input  logic [DW-1:0]     ram_dq,
    output logic              ram_ce_n,
    output logic              ram_oe_n,
    output logic              ram_we_n,
    output logic              ram_adv_n,
    output logic              ram_ub_n,
    output logic              ram_lb_n
);

    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              grant_q, grant_d;
    logic [RAM_AW-1:0] ram_a_q, ram_a_d;
    logic [DW-1:0]     rd_data_q, rd_data_d;
    logic              sel_n_q, sel_n_d;
    logic              chr_ack_q, chr_ack_d, prg_ack_q, prg_ack_d;
    logic              chr_rdy_q, chr_rdy_d, prg_rdy_q, prg_rdy_d;
    logic              gnt_vld, gnt_port;

    rr_arb2 u_rr_arb2 (
        .req0_i       (chr_req),
        .req1_i       (prg_req),
        .last_grant_i (grant_q),
        .gnt_vld_o    (gnt_vld),
        .gnt_port_o   (gnt_port)
    );

    // grant_q is both the in-flight port index and the round-robin history.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            grant_q   <= PORT_PRG;
            ram_a_q   <= '0;
            rd_data_q <= '0;
            sel_n_q   <= 1'b1;
            chr_ack_q <= 1'b0;
            prg_ack_q <= 1'b0;
            chr_rdy_q <= 1'b0;
            prg_rdy_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            grant_q   <= grant_d;
            ram_a_q   <= ram_a_d;
            rd_data_q <= rd_data_d;
            sel_n_q   <= sel_n_d;
            chr_ack_q <= chr_ack_d;
            prg_ack_q <= prg_ack_d;
            chr_rdy_q <= chr_rdy_d;
            prg_rdy_q <= prg_rdy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        grant_d = grant_q;
        ram_a_d = ram_a_q;
        case (state_q)
            IDLE: begin
                if (gnt_vld) begin
                    state_d = ACCESS;
                    cnt_d   = CNT_INIT;
                    grant_d = gnt_port;
                    ram_a_d = (gnt_port == PORT_PRG) ? map_addr(PRG_BASE, prg_addr)
                                                     : map_addr(CHR_BASE, chr_addr);
                end
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Registered outputs are decoded from the upcoming state so they line up
    // with the state they belong to.
    always_comb begin
        sel_n_d   = (state_d != ACCESS);
        chr_ack_d = (state_q == IDLE) && (state_d == ACCESS) && (grant_d == PORT_CHR);
        prg_ack_d = (state_q == IDLE) && (state_d == ACCESS) && (grant_d == PORT_PRG);
        chr_rdy_d = (state_d == DONE) && (grant_q == PORT_CHR);
        prg_rdy_d = (state_d == DONE) && (grant_q == PORT_PRG);
        rd_data_d = (state_d == DONE) ? ram_dq : rd_data_q;
    end

    assign chr_req_ack = chr_ack_q;
    assign prg_req_ack = prg_ack_q;
    assign chr_ready   = chr_rdy_q;
    assign prg_ready   = prg_rdy_q;
    assign rd_data     = rd_data_q;
    assign ram_a       = ram_a_q;
    assign ram_ce_n    = sel_n_q;
    assign ram_oe_n    = sel_n_q;
    assign ram_we_n    = 1'b1;
    assign ram_adv_n   = 1'b0;
    assign ram_ub_n    = 1'b0;
    assign ram_lb_n    = 1'b0;

endmodule

// File: tb/tb_cellram_arbiter.sv
// Bench for cellram_arbiter: directed corner steps plus randomized traffic
// scored against a cycle-timeline model of grants, acks, readies and data.
module tb_cellram_arbiter;
    import cellram_pkg::*;

    localparam int W = 7;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        chr_req = 1'b0, prg_req = 1'b0;
    logic [19:0] chr_addr = '0, prg_addr = '0;
    logic        chr_req_ack, chr_ready, prg_req_ack, prg_ready;
    logic [15:0] rd_data, ram_dq;
    logic [22:0] ram_a;
    logic        ram_ce_n, ram_oe_n, ram_we_n, ram_adv_n, ram_ub_n, ram_lb_n;

    logic        chr_req1 = 1'b0, prg_req1 = 1'b0;
    logic [19:0] chr_addr1 = '0, prg_addr1 = '0;
    logic        chr_req_ack1, chr_ready1, prg_req_ack1, prg_ready1;
    logic [15:0] rd_data1, ram_dq1;
    logic [22:0] ram_a1;
    logic        ram_ce_n1, ram_oe_n1, ram_we_n1, ram_adv_n1, ram_ub_n1, ram_lb_n1;

    int n_pass = 0, n_total = 0, n_fail = 0;

    cellram_arbiter #(.WAIT_CYCLES(W)) dut (
        .clk(clk), .rst(rst),
        .chr_req(chr_req), .chr_addr(chr_addr), .chr_req_ack(chr_req_ack), .chr_ready(chr_ready),
        .prg_req(prg_req), .prg_addr(prg_addr), .prg_req_ack(prg_req_ack), .prg_ready(prg_ready),
        .rd_data(rd_data), .ram_a(ram_a), .ram_dq(ram_dq),
        .ram_ce_n(ram_ce_n), .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n),
        .ram_adv_n(ram_adv_n), .ram_ub_n(ram_ub_n), .ram_lb_n(ram_lb_n)
    );

    cellram_arbiter #(.WAIT_CYCLES(1), .PRG_BASE(23'h7FFFF0)) dut1 (
        .clk(clk), .rst(rst),
        .chr_req(chr_req1), .chr_addr(chr_addr1), .chr_req_ack(chr_req_ack1), .chr_ready(chr_ready1),
        .prg_req(prg_req1), .prg_addr(prg_addr1), .prg_req_ack(prg_req_ack1), .prg_ready(prg_ready1),
        .rd_data(rd_data1), .ram_a(ram_a1), .ram_dq(ram_dq1),
        .ram_ce_n(ram_ce_n1), .ram_oe_n(ram_oe_n1), .ram_we_n(ram_we_n1),
        .ram_adv_n(ram_adv_n1), .ram_ub_n(ram_ub_n1), .ram_lb_n(ram_lb_n1)
    );

    // RAM contents; low addresses of the CHR region read back as their own address.
    function automatic logic [15:0] data_of(input logic [22:0] a);
        return a[15:0] ^ {9'h0, a[22:16]};
    endfunction

    // Async RAM: data only becomes valid once OE has been low for the wait time.
    int   low0 = 0, low1 = 0;
    logic beef_mode = 1'b0;
    always @(posedge clk) low0 <= (ram_oe_n || ram_ce_n) ? 0 : low0 + 1;
    always @(posedge clk) low1 <= (ram_oe_n1 || ram_ce_n1) ? 0 : low1 + 1;
    assign ram_dq  = (!ram_oe_n && !ram_ce_n && low0 >= W - 1)
                   ? (beef_mode ? 16'hBEEF : data_of(ram_a)) : 16'h0BAD;
    assign ram_dq1 = (!ram_oe_n1 && !ram_ce_n1) ? data_of(ram_a1) : 16'h0BAD;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic next_req(input logic acked, inout logic req, inout logic [19:0] addr);
        if (acked) begin
            req  = ($urandom % 2) == 0;
            addr = 20'($urandom);
        end else if (!req) begin
            if ($urandom % 4 == 0) begin
                req  = 1'b1;
                addr = 20'($urandom);
            end
        end else if ($urandom % 10 == 0) begin
            req = 1'b0;
        end
    endtask

    // mode 0: CHR burst with incrementing address, 1: permanent contention,
    // 2: random requests and withdrawals on both ports. Starts from reset.
    task automatic run_traffic(input int mode, input int n_grants, input int max_cycles);
        int          c, m_grants, ack_cyc, rdy_cyc, m_free, obs_acks, obs_last_rdy, repeats;
        logic        m_port, m_last, last_obs, acked_chr, acked_prg, in_acc;
        logic [22:0] m_addr;
        logic [15:0] m_data;
        logic [5:0]  exp_v, obs_v;
        rst      = 1'b1;
        chr_req  = (mode != 2);
        prg_req  = (mode == 1);
        chr_addr = (mode == 0) ? 20'h0 : 20'($urandom);
        prg_addr = 20'($urandom);
        tick();
        tick();
        rst = 1'b0;
        c = 0; m_grants = 0; ack_cyc = -1000; rdy_cyc = -1000; m_free = 0;
        obs_acks = 0; obs_last_rdy = -1; repeats = 0;
        m_port = PORT_CHR; m_last = PORT_PRG; last_obs = PORT_CHR;
        m_addr = '0; m_data = '0;
        while (c < max_cycles && !(m_grants >= n_grants && c > rdy_cyc)) begin
            in_acc = (c >= ack_cyc) && (c < ack_cyc + W);
            exp_v  = {c == ack_cyc && m_port == PORT_CHR, c == ack_cyc && m_port == PORT_PRG,
                      c == rdy_cyc && m_port == PORT_CHR, c == rdy_cyc && m_port == PORT_PRG,
                      in_acc, in_acc};
            obs_v  = {chr_req_ack, prg_req_ack, chr_ready, prg_ready, !ram_ce_n, !ram_oe_n};
            check("traffic_pulses", 32'(obs_v), 32'(exp_v));
            if (c == ack_cyc) check("traffic_ram_a", 32'(ram_a), 32'(m_addr));
            if (c == rdy_cyc) check("traffic_rd_data", 32'(rd_data), 32'(m_data));
            if (chr_req_ack || prg_req_ack) begin
                if (obs_acks > 0 && prg_req_ack == last_obs) repeats++;
                last_obs = prg_req_ack;
                obs_acks++;
            end
            if (chr_ready || prg_ready) obs_last_rdy = c;

            acked_chr = (c == ack_cyc) && (m_port == PORT_CHR);
            acked_prg = (c == ack_cyc) && (m_port == PORT_PRG);
            if (m_grants >= n_grants) begin
                chr_req = 1'b0;
                prg_req = 1'b0;
            end else if (mode == 0) begin
                if (acked_chr) chr_addr = chr_addr + 20'd1;
            end else if (mode == 1) begin
                if (acked_chr) chr_addr = 20'($urandom);
                if (acked_prg) prg_addr = 20'($urandom);
            end else begin
                next_req(acked_chr, chr_req, chr_addr);
                next_req(acked_prg, prg_req, prg_addr);
            end

            // Arbiter is free from the IDLE cycle after DONE; ties go to the other port.
            if (c >= m_free && (chr_req || prg_req)) begin
                m_port  = (chr_req && prg_req) ? ~m_last : (prg_req ? PORT_PRG : PORT_CHR);
                m_last  = m_port;
                m_addr  = (m_port == PORT_PRG) ? PRG_BASE_DEF + {3'b000, prg_addr}
                                               : CHR_BASE_DEF + {3'b000, chr_addr};
                m_data  = data_of(m_addr);
                ack_cyc = c + 1;
                rdy_cyc = c + W + 1;
                m_free  = c + W + 2;
                m_grants++;
            end
            tick();
            c++;
        end
        check("traffic_ack_count", 32'(obs_acks), 32'(n_grants));
        if (mode == 0) check("burst_last_ready_cycle", 32'(obs_last_rdy), 32'(n_grants * (W + 2) - 1));
        if (mode == 1) check("contention_repeats", 32'(repeats), 32'(0));
    endtask

    initial begin
        int bad;

        // Reset values on both instances
        @(negedge clk);
        check("rst_ce_oe", 32'({ram_ce_n, ram_oe_n}), 32'(2'b11));
        check("rst_pulses", 32'({chr_req_ack, prg_req_ack, chr_ready, prg_ready}), 32'(0));
        check("rst_ram_a", 32'(ram_a), 32'(0));
        check("rst_rd_data", 32'(rd_data), 32'(0));
        check("const_pins", 32'({ram_we_n, ram_adv_n, ram_ub_n, ram_lb_n}), 32'(4'b1000));
        check("rst1_ce_oe", 32'({ram_ce_n1, ram_oe_n1, ram_a1, rd_data1}), 32'({2'b11, 39'h0}));

        // Single CHR read
        rst = 1'b0;
        tick();
        beef_mode = 1'b1;
        chr_req   = 1'b1;
        chr_addr  = 20'h00ABC;
        tick();
        check("single_ack", 32'({chr_req_ack, prg_req_ack}), 32'(2'b10));
        check("single_ram_a", 32'(ram_a), 32'h000ABC);
        check("single_ce_oe", 32'({ram_ce_n, ram_oe_n}), 32'(2'b00));
        chr_req  = 1'b0;
        chr_addr = 20'h00ABD;
        for (int k = 2; k <= W; k++) begin
            tick();
            check("single_wait", 32'({chr_req_ack, chr_ready, ram_ce_n}), 32'(3'b000));
        end
        tick();
        check("single_ready", 32'({chr_ready, prg_ready, ram_ce_n, ram_oe_n}), 32'(4'b1011));
        check("single_rd_data", 32'(rd_data), 32'hBEEF);
        tick();
        check("single_ready_pulse", 32'(chr_ready), 32'(0));
        beef_mode = 1'b0;

        // Reset in the middle of an access
        chr_req  = 1'b1;
        chr_addr = 20'h00123;
        tick();
        chr_req = 1'b0;
        tick();
        check("abort_pre_ce", 32'(ram_ce_n), 32'(0));
        rst = 1'b1;
        #1;
        check("abort_ce_oe", 32'({ram_ce_n, ram_oe_n}), 32'(2'b11));
        check("abort_pulses", 32'({chr_req_ack, prg_req_ack, chr_ready, prg_ready}), 32'(0));
        tick();
        rst = 1'b0;
        bad = 0;
        for (int k = 0; k < W + 4; k++) begin
            tick();
            if (chr_ready || prg_ready || !ram_ce_n) bad++;
        end
        check("abort_no_ready", 32'(bad), 32'(0));
        chr_req  = 1'b1;
        chr_addr = 20'h00456;
        tick();
        check("post_reset_ack", 32'({chr_req_ack, ram_ce_n}), 32'(2'b10));
        check("post_reset_ram_a", 32'(ram_a), 32'h000456);
        chr_req = 1'b0;
        repeat (W) tick();
        check("post_reset_ready", 32'({chr_ready, rd_data}), 32'h1_0456);

        // Withdrawal: CHR drops after its ack, PRG pulses while busy
        tick();
        chr_req  = 1'b1;
        chr_addr = 20'h00777;
        tick();
        check("wd_ack", 32'(chr_req_ack), 32'(1));
        tick();
        chr_req = 1'b0;
        tick();
        prg_req  = 1'b1;
        prg_addr = 20'h00055;
        tick();
        prg_req = 1'b0;
        repeat (W - 3) tick();
        check("wd_ready", 32'({chr_ready, rd_data}), 32'h1_0777);
        bad = 0;
        for (int k = 0; k < 2 * (W + 2); k++) begin
            tick();
            if (prg_req_ack || prg_ready || !ram_ce_n) bad++;
        end
        check("wd_prg_ignored", 32'(bad), 32'(0));

        // One wait state, PRG base wrapping past the top of the RAM
        prg_req1  = 1'b1;
        prg_addr1 = 20'h00020;
        tick();
        check("w1_ack", 32'({prg_req_ack1, chr_req_ack1, ram_ce_n1}), 32'(3'b100));
        check("w1_ram_a_wrap", 32'(ram_a1), 32'h000010);
        tick();
        check("w1_ready", 32'({prg_ready1, ram_ce_n1}), 32'(2'b11));
        check("w1_rd_data", 32'(rd_data1), 32'h0010);
        tick();
        check("w1_idle", 32'({prg_req_ack1, prg_ready1, ram_ce_n1}), 32'(3'b001));
        tick();
        check("w1_period", 32'(prg_req_ack1), 32'(1));
        prg_req1 = 1'b0;
        repeat (3) tick();

        // Window-fill burst, contention from reset, then random traffic
        run_traffic(0, 4096, 40000);
        run_traffic(1, 16, 1000);
        run_traffic(2, 300, 10000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/cellram_arbiter.md
# cellram_arbiter

Two-port read arbiter between the CHR ROM window and the PRG ROM window on one side, and the Nexys3 cellular RAM (async mode, 16-bit words) on the other. Each requester holds `req`, advances its address on a one-cycle `req_ack`, and stores the word on a one-cycle `ready`. This is the same handshake the CHR window fill logic expects. The arbiter serialises requests round-robin, offsets each port into its own region of the 23-bit RAM word space, and runs fixed-wait-state async read cycles.

## Interface
- `WAIT_CYCLES`, default 7: cycles `ram_oe_n`/`ram_ce_n` are held low per read. Legal range 1..15.
- `CHR_BASE`, default 23'h000000: word offset added to CHR port addresses.
- `PRG_BASE`, default 23'h100000: word offset added to PRG port addresses.

Ports:
- `clk`  in  1: system clock, the only clock.
- `rst`  in  1: reset, asynchronous, active-high.
- `chr_req`  in  1: CHR port request, level.
- `chr_addr`  in  20: CHR word address.
- `chr_req_ack`  out  1: one-cycle pulse; CHR address accepted.
- `chr_ready`  out  1: one-cycle pulse; `rd_data` holds the CHR word.
- `prg_req`  in  1: PRG port request, level.
- `prg_addr`  in  20: PRG word address.
- `prg_req_ack`  out  1: one-cycle pulse; PRG address accepted.
- `prg_ready`  out  1: one-cycle pulse; `rd_data` holds the PRG word.
- `rd_data`  out  16: last word read. Shared by both ports.
- `ram_a`  out  23: RAM word address.
- `ram_dq`  in  16: RAM data. Read-only use.
- `ram_ce_n`, `ram_oe_n`  out  1: chip enable and output enable.
- `ram_we_n`, `ram_adv_n`, `ram_ub_n`, `ram_lb_n`  out  1: held constant at 1, 0, 0, 0.

## Operation
- States: IDLE, ACCESS, DONE.
- **IDLE.**
  - If no `req` is high, stay in IDLE.
  - If exactly one port requests, grant it.
  - If both request, grant the port opposite `last_grant`.
  - On the grant edge: latch `ram_a <= BASE_port + {3'b0, addr_port}` (mod 2^23), latch the port index, set `last_grant`, load the wait counter with `WAIT_CYCLES-1`, go to ACCESS.
- **ACCESS.**
  - `ram_ce_n = ram_oe_n = 0`.
  - First cycle only: the granted port's `req_ack = 1`.
  - The counter decrements each cycle. When it reaches 0: capture `rd_data <= ram_dq`, go to DONE.
- **DONE.**
  - `ram_ce_n = ram_oe_n = 1`.
  - The granted port's `ready = 1` for this cycle.
  - Next state is IDLE.
- Each port has at most one outstanding request. The `ready` for a request always precedes that port's next `req_ack`.
- The `req` inputs are sampled only in IDLE.
  - A `req` that drops after `req_ack` still receives its `ready`.
  - A `req` that drops before the grant is ignored.
- Outputs `req_ack`, `ready`, `ram_*` and `rd_data` are all registered. No combinational path runs from the inputs to them.
- **Reset.** Asynchronous; it aborts any access with no `ready` pulse. Reset values:
  - State = IDLE, `last_grant` = PRG (so CHR wins the first tie).
  - `ram_a` = 0, `rd_data` = 0.
  - `ram_ce_n = ram_oe_n = 1`.
  - All `req_ack` and `ready` = 0.

## Timing
- Cycle 0: IDLE sees `req`; the grant edge is at the end of cycle 0.
- Cycles 1..W are ACCESS (W = `WAIT_CYCLES`). `req_ack` is high in cycle 1; the requester advances its address at the end of cycle 1.
- `ram_dq` is sampled at the end of cycle W.
- Cycle W+1 is DONE: `ready` high, `rd_data` valid.
- Cycle W+2 is IDLE, and the next grant edge is at its end.
- Period per word is W+2 cycles. With default W=7 that is 9 cycles, so 4096 words take 36864 cycles with no contention.
- Under continuous contention the ports alternate strictly, giving one word per port per 2(W+2) cycles.
- Address maps are checked mod 2^23, e.g. `PRG_BASE` = 23'h7FFFF0 with `prg_addr` = 20'h00020 gives `ram_a` = 23'h000010.

## Structure
- Shared package `cellram_pkg`:
  - State enum (IDLE/ACCESS/DONE).
  - Port index constants `PORT_CHR` = 0, `PORT_PRG` = 1.
  - Default base constants.
  - Width constants `RAM_AW` = 23, `REQ_AW` = 20, `DW` = 16.
- One sub-module, `rr_arb2`: combinational 2-input round-robin grant from (`req0`, `req1`, `last_grant`). The `last_grant` register stays in the parent.

## Test plan
- **Reset values:** assert `rst` mid-ACCESS → same cycle `ram_ce_n = ram_oe_n = 1`, no `ready` pulse ever follows. Release, then `chr_req` → a new access starts cleanly.
- **Single CHR read:** `chr_req = 1`, `chr_addr` = 20'h00ABC, model returns 16'hBEEF.
  - `chr_req_ack` in cycle 1, `ram_a` = 23'h000ABC.
  - `chr_ready` in cycle 8 with `rd_data` = 16'hBEEF.
- **CHR burst emulating the window fill:** requester increments its address on each `req_ack` over 4096 words, model data = address.
  - Each `ready` carries the address acked in that request's cycle-1 `req_ack` (the previous one).
  - The final `ready` arrives 36864 cycles after the first grant.
- **Contention:** both `req` high from reset.
  - Grants CHR, PRG, CHR, PRG...
  - `prg` accesses show `ram_a` = 23'h100000 + `prg_addr`.
  - Neither port is granted twice in a row while the other requests.
- **Request withdrawal:**
  - `chr_req` dropped in the cycle after `chr_req_ack` → `chr_ready` still pulses.
  - `prg_req` pulsed for one cycle while the arbiter is busy → never granted.
- **Parameter corner:** `WAIT_CYCLES` = 1 → `req_ack` and the data capture fall in the same ACCESS cycle, `ready` in cycle 2, period 3 cycles.
